// File: rtl/lifo_line_unstack_if.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_line_unstack_if
//  Description : Stream bundle for the line reverser. Carries the input beat
//                handshake, the output beat handshake and the status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lifo_line_unstack_if #(
    parameter int DWIDTH = 22,
    parameter int AWIDTH = 11
);
    logic [AWIDTH-1:0] cfg_width;
    logic              s_valid;
    logic              s_ready;
    logic [DWIDTH-1:0] s_data;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [DWIDTH-1:0] m_data;
    logic              m_first;
    logic              m_last;
    logic              busy;
    logic              err_len;

    // Reverser side of the bundle
    modport slave (
        input  cfg_width, s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_first, m_last, busy, err_len
    );

    // Producer/consumer side of the bundle
    modport master (
        output cfg_width, s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_first, m_last, busy, err_len
    );
endinterface
`default_nettype wire

// File: rtl/lifo_line_unstack.sv
`default_nettype none
// ============================================================================
//  Module      : lifo_line_unstack
//  Description : Line reverser. Stores one line in a dual-port line memory and
//                replays it in reverse order. The write direction alternates
//                per line so the next line fills slots as they are drained.
//  Revision    : 1.0 - initial release
// ============================================================================
module lifo_line_unstack #(
    parameter int DWIDTH = 22,
    parameter int AWIDTH = 11,
    parameter int MAX_W  = 1936
) (
    input  wire logic          clk,
    input  wire logic          rst,
    lifo_line_unstack_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [AWIDTH-1:0] C_MIN_W = AWIDTH'(2);
    localparam logic [AWIDTH-1:0] C_MAX_W = AWIDTH'(MAX_W);

    state_t            r_state;
    state_t            w_state_nxt;

    // Write side: line being filled
    logic              r_wdir;
    logic [AWIDTH-1:0] r_wr_cnt;
    logic [AWIDTH-1:0] r_wr_w;
    logic              r_nxt_done;      // next line fully written while draining

    // Read side: line being drained
    logic              r_rdir;
    logic [AWIDTH-1:0] r_rd_cnt;
    logic [AWIDTH-1:0] r_rd_w;

    // Line memory and its read register
    logic [DWIDTH-1:0] r_mem [0:MAX_W-1];
    logic [DWIDTH-1:0] r_rdata;
    logic              r_rv;
    logic              r_rfirst;
    logic              r_rlast;

    // Two-entry output skid
    logic [DWIDTH-1:0] r_sk_data [0:1];
    logic [1:0]        r_sk_first;
    logic [1:0]        r_sk_last;
    logic              r_sk_head;
    logic [1:0]        r_sk_cnt;

    logic              r_err;

    logic [AWIDTH-1:0] w_cfg_w;
    logic [AWIDTH-1:0] w_fill_w;
    logic [AWIDTH:0]   w_slack;
    logic              w_room;
    logic              w_s_ready;
    logic              w_acc;
    logic              w_wr_last;
    logic              w_close;
    logic [AWIDTH-1:0] w_wr_addr;
    logic              w_rd_en;
    logic              w_rd_last;
    logic              w_drain_end;
    logic [AWIDTH-1:0] w_rd_addr;
    logic              w_direct;
    logic              w_push;
    logic              w_pop;
    logic              w_tail;

    // Clamp the configured width into the legal range
    always_comb begin
        w_cfg_w = bus.cfg_width;
        if (bus.cfg_width < C_MIN_W) begin
            w_cfg_w = C_MIN_W;
        end else if (bus.cfg_width > C_MAX_W) begin
            w_cfg_w = C_MAX_W;
        end
    end

    // Width of the line being written: live config on its first beat, then held
    assign w_fill_w = (r_wr_cnt == '0) ? w_cfg_w : r_wr_w;

    // Extra headroom needed when a reverse-written line is narrower than the
    // held line: its first slot lands deeper in the region still being read.
    // For equal widths this is zero and the rule reduces to wr_cnt < rd_cnt.
    always_comb begin
        w_slack = '0;
        if (r_wdir && (r_rd_w > w_fill_w)) begin
            w_slack = {1'b0, r_rd_w} - {1'b0, w_fill_w};
        end
    end

    assign w_room    = ({1'b0, r_wr_cnt} + w_slack) < {1'b0, r_rd_cnt};
    assign w_s_ready = (r_state != ST_DRAIN) || (!r_nxt_done && w_room);
    assign w_acc     = bus.s_valid && w_s_ready;
    assign w_wr_last = (r_wr_cnt == (w_fill_w - AWIDTH'(1)));
    assign w_close   = w_acc && w_wr_last;
    assign w_wr_addr = r_wdir ? (w_fill_w - AWIDTH'(1) - r_wr_cnt) : r_wr_cnt;

    // A read is issued only while the skid plus the in-flight read has room
    assign w_rd_en     = (r_state == ST_DRAIN) && ((r_sk_cnt + {1'b0, r_rv}) < 2'd2);
    assign w_rd_last   = (r_rd_cnt == (r_rd_w - AWIDTH'(1)));
    assign w_drain_end = w_rd_en && w_rd_last;
    assign w_rd_addr   = r_rdir ? r_rd_cnt : (r_rd_w - AWIDTH'(1) - r_rd_cnt);

    // Skid control: a read result bypasses the skid when it is empty and taken
    assign w_direct = r_rv && (r_sk_cnt == 2'd0) && bus.m_ready;
    assign w_pop    = (r_sk_cnt != 2'd0) && bus.m_ready;
    assign w_push   = r_rv && !w_direct;
    assign w_tail   = r_sk_head ^ r_sk_cnt[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_close) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drain_end) begin
                    if (r_nxt_done || w_close) begin
                        w_state_nxt = ST_DRAIN;
                    end else if ((r_wr_cnt != '0) || w_acc) begin
                        w_state_nxt = ST_FILL;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write/read counters, line widths and directions, length check
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdir     <= 1'b0;
            r_wr_cnt   <= '0;
            r_wr_w     <= '0;
            r_nxt_done <= 1'b0;
            r_rdir     <= 1'b0;
            r_rd_cnt   <= '0;
            r_rd_w     <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_acc && (bus.s_last != w_wr_last);

            if (w_acc) begin
                if (r_wr_cnt == '0) begin
                    r_wr_w <= w_cfg_w;
                end
                if (w_close) begin
                    r_wr_cnt <= '0;
                    r_wdir   <= ~r_wdir;
                end else begin
                    r_wr_cnt <= r_wr_cnt + AWIDTH'(1);
                end
            end

            if (r_state == ST_DRAIN) begin
                if (w_drain_end) begin
                    r_nxt_done <= 1'b0;
                end else if (w_close) begin
                    r_nxt_done <= 1'b1;
                end
            end

            if ((r_state == ST_FILL) && w_close) begin
                r_rd_cnt <= '0;
                r_rd_w   <= r_wr_w;
                r_rdir   <= r_wdir;
            end else if (w_rd_en) begin
                if (w_drain_end) begin
                    r_rd_cnt <= '0;
                    if (r_nxt_done || w_close) begin
                        r_rd_w <= r_wr_w;
                        r_rdir <= ~r_rdir;
                    end
                end else begin
                    r_rd_cnt <= r_rd_cnt + AWIDTH'(1);
                end
            end
        end
    end

    // Line memory: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_mem[w_wr_addr] <= bus.s_data;
        end
        if (w_rd_en) begin
            r_rdata <= r_mem[w_rd_addr];
        end
    end

    // Read-valid tags and output skid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rv         <= 1'b0;
            r_rfirst     <= 1'b0;
            r_rlast      <= 1'b0;
            r_sk_data[0] <= '0;
            r_sk_data[1] <= '0;
            r_sk_first   <= '0;
            r_sk_last    <= '0;
            r_sk_head    <= 1'b0;
            r_sk_cnt     <= 2'd0;
        end else begin
            r_rv <= w_rd_en;
            if (w_rd_en) begin
                r_rfirst <= (r_rd_cnt == '0);
                r_rlast  <= w_rd_last;
            end
            if (w_push) begin
                r_sk_data[w_tail]  <= r_rdata;
                r_sk_first[w_tail] <= r_rfirst;
                r_sk_last[w_tail]  <= r_rlast;
            end
            if (w_pop) begin
                r_sk_head <= ~r_sk_head;
            end
            r_sk_cnt <= r_sk_cnt + 2'(w_push) - 2'(w_pop);
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = (r_sk_cnt != 2'd0) || r_rv;
    assign bus.m_data  = (r_sk_cnt != 2'd0) ? r_sk_data[r_sk_head]  : (r_rv ? r_rdata  : '0);
    assign bus.m_first = (r_sk_cnt != 2'd0) ? r_sk_first[r_sk_head] : (r_rv && r_rfirst);
    assign bus.m_last  = (r_sk_cnt != 2'd0) ? r_sk_last[r_sk_head]  : (r_rv && r_rlast);
    assign bus.busy    = (r_state != ST_IDLE) || bus.m_valid || r_rv;
    assign bus.err_len = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lifo_line_unstack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lifo_line_unstack
//  Description : Directed self-checking bench for the line reverser.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lifo_line_unstack;
    localparam int DW = 22;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lifo_line_unstack_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    lifo_line_unstack #(.DWIDTH(DW), .AWIDTH(AW), .MAX_W(1936)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [AW-1:0] cfg;
        logic          bad;
        logic          eol;
    } in_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } out_t;

    in_t  in_q[$];
    out_t exp_q[$];
    int   lat_q[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    logic exp_err = 1'b0;
    int   stalls;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Queue one input line and its reversed expectation
    task automatic add_line(input int cfg, input int w_eff, input int base, input int last_idx);
        for (int i = 0; i < w_eff; i++) begin
            in_t e;
            e.data = DW'(base + i);
            e.last = (i == last_idx);
            e.cfg  = AW'(cfg);
            e.bad  = ((i == last_idx) != (i == w_eff - 1));
            e.eol  = (i == w_eff - 1);
            in_q.push_back(e);
        end
        for (int i = w_eff - 1; i >= 0; i--) begin
            out_t o;
            o.data  = DW'(base + i);
            o.first = (i == w_eff - 1);
            o.last  = (i == 0);
            exp_q.push_back(o);
        end
    endtask

    // Stream queued lines through; ready_mode 0 = always ready, 1 = 1010...
    task automatic run(input int ready_mode, input bit chk_lat, input int budget);
        int n    = 0;
        bit seen = 1'b0;
        stalls = 0;
        while (((in_q.size() > 0) || (exp_q.size() > 0)) && (n < budget)) begin
            @(posedge clk); #1;
            if (in_q.size() > 0) begin
                bus.s_valid   = 1'b1;
                bus.s_data    = in_q[0].data;
                bus.s_last    = in_q[0].last;
                bus.cfg_width = in_q[0].cfg;
            end else begin
                bus.s_valid = 1'b0;
                bus.s_last  = 1'b0;
            end
            bus.m_ready = (ready_mode == 0) ? 1'b1 : ((n % 2) == 0);
            @(negedge clk);
            check("err_len", bus.err_len, exp_err);
            exp_err = 1'b0;
            if (bus.m_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", bus.m_valid, 0);
                end else begin
                    check("m_data",  bus.m_data,  exp_q[0].data);
                    check("m_first", bus.m_first, exp_q[0].first);
                    check("m_last",  bus.m_last,  exp_q[0].last);
                    if (exp_q[0].first && !seen) begin
                        seen = 1'b1;
                        if (lat_q.size() > 0) begin
                            if (chk_lat) check("latency", cyc, lat_q[0] + 2);
                            void'(lat_q.pop_front());
                        end
                    end
                    if (bus.m_ready) begin
                        if (exp_q[0].first) seen = 1'b0;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                exp_err = in_q[0].bad;
                if (in_q[0].eol) lat_q.push_back(cyc);
                void'(in_q.pop_front());
            end else if (bus.s_valid) begin
                stalls++;
            end
            n++;
        end
        check("run_done", in_q.size() + exp_q.size(), 0);
        in_q.delete();
        exp_q.delete();
        lat_q.delete();
    endtask

    // Quiet cycles; the reverser must settle to empty
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
            bus.m_ready = 1'b1;
            @(negedge clk);
            check("err_len_idle", bus.err_len, exp_err);
            exp_err = 1'b0;
        end
        check("m_valid_idle", bus.m_valid, 0);
        check("busy_idle",    bus.busy,    0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cfg_width = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data",  bus.m_data,  0);
        check("rst_m_first", bus.m_first, 0);
        check("rst_m_last",  bus.m_last,  0);
        check("rst_busy",    bus.busy,    0);
        check("rst_err_len", bus.err_len, 0);

        // Single W=8 line, 0..7 -> 7..0, first output 2 cycles after last input
        add_line(8, 8, 0, 7);
        run(0, 1'b1, 100);
        idle(3);

        // Back-to-back lines: one stall cycle at the start of the second drain
        add_line(8, 8, 0, 7);
        add_line(8, 8, 10, 7);
        run(0, 1'b1, 200);
        check("b2b_stalls", stalls, 1);
        idle(3);

        // Output back-pressure 1010... across two W=16 lines
        add_line(16, 16, 40, 15);
        add_line(16, 16, 80, 15);
        run(1, 1'b0, 400);
        idle(3);

        // Maximum width, three lines with alternating direction
        add_line(1936, 1936, 1000, 1935);
        add_line(1936, 1936, 5000, 1935);
        add_line(1936, 1936, 9000, 1935);
        run(0, 1'b1, 8000);
        check("max_stalls", stalls, 2);
        idle(3);

        // cfg_width=0 clamps to 2; early s_last on beat 3 of an 8-beat line
        add_line(0, 2, 100, 1);
        add_line(8, 8, 200, 3);
        run(0, 1'b1, 200);
        idle(3);

        // Reset while draining with the next line partly written
        bus.m_ready   = 1'b0;
        bus.cfg_width = AW'(8);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(300 + i);
            bus.s_last  = (i == 7) || (i == 15);
            bus.m_ready = 1'b0;
        end
        @(negedge clk);
        check("pre_rst_busy",   bus.busy,    1);
        check("pre_rst_mvalid", bus.m_valid, 1);
        check("pre_rst_data",   bus.m_data,  307);
        check("pre_rst_first",  bus.m_first, 1);
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_m_valid", bus.m_valid, 0);
        check("mid_rst_s_ready", bus.s_ready, 1);
        check("mid_rst_busy",    bus.busy,    0);
        exp_err = 1'b0;
        add_line(4, 4, 500, 3);
        run(0, 1'b1, 100);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
